// File: rtl/asap_pkg.sv
// Shared encoding for the ASAP-1 control path: opcodes, sequencer length and
// control-word bit positions used by the decoder, the datapath and the bench.
package asap_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned CW_W      = 16;
  localparam int unsigned NUM_STEPS = 5;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Control-word bit positions, MSB first in the order hlt..fi.
  localparam int unsigned CW_HLT = 15;
  localparam int unsigned CW_MI  = 14;
  localparam int unsigned CW_RI  = 13;
  localparam int unsigned CW_RO  = 12;
  localparam int unsigned CW_IO  = 11;
  localparam int unsigned CW_II  = 10;
  localparam int unsigned CW_AI  = 9;
  localparam int unsigned CW_AO  = 8;
  localparam int unsigned CW_EO  = 7;
  localparam int unsigned CW_SU  = 6;
  localparam int unsigned CW_BI  = 5;
  localparam int unsigned CW_OI  = 4;
  localparam int unsigned CW_CE  = 3;
  localparam int unsigned CW_CO  = 2;
  localparam int unsigned CW_J   = 1;
  localparam int unsigned CW_FI  = 0;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decoder: (opcode, T-state, latched flags) -> control word.
module microcode_rom
  import asap_pkg::*;
(
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              zf_i,
  input  logic              cf_i,
  output logic [CW_W-1:0]   cw_o
);

  // Fetch is common to every opcode; execute steps decode per opcode.
  always_comb begin
    cw_o = '0;
    case (step_i)
      3'd0: begin
        cw_o[CW_CO] = 1'b1;
        cw_o[CW_MI] = 1'b1;
      end
      3'd1: begin
        cw_o[CW_RO] = 1'b1;
        cw_o[CW_II] = 1'b1;
        cw_o[CW_CE] = 1'b1;
      end
      3'd2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_J]  = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IO] = cf_i;
            cw_o[CW_J]  = cf_i;
          end
          OP_JZ: begin
            cw_o[CW_IO] = zf_i;
            cw_o[CW_J]  = zf_i;
          end
          OP_OUT: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_OI] = 1'b1;
          end
          OP_HLT: cw_o[CW_HLT] = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_BI] = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_RI] = 1'b1;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          cw_o[CW_EO] = 1'b1;
          cw_o[CW_AI] = 1'b1;
          cw_o[CW_FI] = 1'b1;
          cw_o[CW_SU] = (opcode_i == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ASAP-1 control unit: instruction register, five-state sequencer, flags and halt
// latch, with reset/halt gating applied on top of the microcode decoder.
module control_unit
  import asap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zf,
  input  logic              cf,
  inout  wire  [DATA_W-1:0] bus,
  output logic              hlt,
  output logic              mi,
  output logic              ri,
  output logic              ro,
  output logic              io,
  output logic              ii,
  output logic              ai,
  output logic              ao,
  output logic              eo,
  output logic              su,
  output logic              bi,
  output logic              oi,
  output logic              ce,
  output logic              co,
  output logic              j,
  output logic              fi,
  output logic [STEP_W-1:0] step,
  output logic              zf_q,
  output logic              cf_q
);

  localparam logic [STEP_W-1:0] StepLast = STEP_W'(NUM_STEPS - 1);

  logic [DATA_W-1:0] ir_q;
  logic [STEP_W-1:0] step_q;
  logic              halted_q;
  logic [CW_W-1:0]   rom_cw;
  logic [CW_W-1:0]   cw;

  microcode_rom u_rom (
    .opcode_i (ir_q[DATA_W-1:DATA_W-OP_W]),
    .step_i   (step_q),
    .zf_i     (zf_q),
    .cf_i     (cf_q),
    .cw_o     (rom_cw)
  );

  // Reset silences everything; a halted CPU asserts only hlt.
  always_comb begin
    cw = '0;
    if (rst_n) begin
      if (halted_q) cw[CW_HLT] = 1'b1;
      else          cw = rom_cw;
    end
  end

  assign hlt  = cw[CW_HLT];
  assign mi   = cw[CW_MI];
  assign ri   = cw[CW_RI];
  assign ro   = cw[CW_RO];
  assign io   = cw[CW_IO];
  assign ii   = cw[CW_II];
  assign ai   = cw[CW_AI];
  assign ao   = cw[CW_AO];
  assign eo   = cw[CW_EO];
  assign su   = cw[CW_SU];
  assign bi   = cw[CW_BI];
  assign oi   = cw[CW_OI];
  assign ce   = cw[CW_CE];
  assign co   = cw[CW_CO];
  assign j    = cw[CW_J];
  assign fi   = cw[CW_FI];
  assign step = step_q;

  // IR operand nibble goes out zero-extended; bus is released otherwise.
  assign bus = cw[CW_IO] ? {{(DATA_W-4){1'b0}}, ir_q[3:0]} : {DATA_W{1'bz}};

  // Sequencer, IR, flags and halt latch; reset wins over every load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q     <= '0;
      step_q   <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      step_q <= (step_q == StepLast) ? '0 : step_q + 1'b1;
      if (cw[CW_II]) ir_q <= bus;
      if (cw[CW_FI]) begin
        zf_q <= zf;
        cf_q <= cf;
      end
      if (cw[CW_HLT]) halted_q <= 1'b1;
    end
  end

endmodule
